// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter in front of a single sram_ctrl command port.
// One transaction in flight at a time; completes on m_ready, aborts on timeout.
module sram_arbiter #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FIXED_PRI = 0,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              m_mem,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              owner,
  output logic              timeout_err
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            r_state, w_state_next;
  logic              r_last_grant;
  logic              r_owner;
  logic              r_rw;
  logic              r_timeout_err;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;

  logic w_win, w_grant, w_complete, w_timeout, w_finish, w_load, w_sel_rw;

  always_comb begin
    w_win = 1'b0;
    if (req0 && req1) begin
      w_win = (FIXED_PRI != 0) ? 1'b0 : ~r_last_grant;
    end else if (req1) begin
      w_win = 1'b1;
    end
    // Gated by reset_n so nothing is acknowledged while reset is held.
    w_grant  = reset_n && (r_state == StIdle) && m_ready && (req0 || req1);
    w_sel_rw = w_win ? rw1 : rw0;
    // First BUSY cycle (r_cnt == 0) ignores m_ready to cover controller latency.
    w_complete = (r_state == StBusy) && (r_cnt != 8'd0) && m_ready;
    w_timeout  = (r_state == StBusy) && !w_complete && ((r_cnt + 8'd1) == TimeoutCnt);
    w_finish   = w_complete || w_timeout;
    w_load     = w_complete && r_rw;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_grant) w_state_next = StBusy;
      StBusy: if (w_finish) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    m_mem   = w_grant;
    m_rw    = 1'b1;
    m_addr  = '0;
    m_wdata = '0;
    if (w_grant) begin
      m_rw    = w_sel_rw;
      m_addr  = w_win ? addr1 : addr0;
      m_wdata = w_win ? wdata1 : wdata0;
    end
    ack0        = w_grant && !w_win;
    ack1        = w_grant && w_win;
    done0       = w_finish && !r_owner;
    done1       = w_finish && r_owner;
    rdata0      = (w_load && !r_owner) ? m_rdata : r_rdata0;
    rdata1      = (w_load && r_owner) ? m_rdata : r_rdata1;
    busy        = (r_state == StBusy);
    owner       = r_owner;
    timeout_err = r_timeout_err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_last_grant  <= 1'b1;
      r_owner       <= 1'b0;
      r_rw          <= 1'b1;
      r_timeout_err <= 1'b0;
      r_cnt         <= 8'd0;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_owner      <= w_win;
        r_last_grant <= w_win;
        r_rw         <= w_sel_rw;
        r_cnt        <= 8'd0;
      end else if (r_state == StBusy) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
      if (w_load && !r_owner) r_rdata0 <= m_rdata;
      if (w_load && r_owner) r_rdata1 <= m_rdata;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a round-robin and a fixed-priority instance share the requester
// inputs, each with its own small sram_ctrl model (ready drops for two cycles per access).
module tb_sram_arbiter;

  logic        clk, reset_n, req0, req1, rw0, rw1, hang;
  logic [17:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;

  logic        ack0 [2], ack1 [2], done0 [2], done1 [2];
  logic        m_mem [2], m_rw [2], m_ready [2], busy [2], owner [2], terr [2];
  logic [17:0] m_addr [2];
  logic [15:0] m_wdata [2], m_rdata [2], rdata0 [2], rdata1 [2];

  logic [1:0]  mc_cnt [2];
  logic        mv [2];
  logic [17:0] ma [2];
  logic [15:0] md [2];

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(18), .DATA_W(16), .FIXED_PRI(0), .TIMEOUT(15)) u_rr (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0[0]), .ack1(ack1[0]), .done0(done0[0]), .done1(done1[0]),
    .rdata0(rdata0[0]), .rdata1(rdata1[0]), .m_mem(m_mem[0]), .m_rw(m_rw[0]),
    .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_ready(m_ready[0]), .m_rdata(m_rdata[0]),
    .busy(busy[0]), .owner(owner[0]), .timeout_err(terr[0])
  );

  sram_arbiter #(.ADDR_W(18), .DATA_W(16), .FIXED_PRI(1), .TIMEOUT(15)) u_fp (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0[1]), .ack1(ack1[1]), .done0(done0[1]), .done1(done1[1]),
    .rdata0(rdata0[1]), .rdata1(rdata1[1]), .m_mem(m_mem[1]), .m_rw(m_rw[1]),
    .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_ready(m_ready[1]), .m_rdata(m_rdata[1]),
    .busy(busy[1]), .owner(owner[1]), .timeout_err(terr[1])
  );

  function automatic logic [15:0] dflt(input logic [17:0] a);
    return (a == 18'h00012) ? 16'hBEEF : {8'h00, a[7:0]};
  endfunction

  assign m_ready[0] = (mc_cnt[0] == 2'd0) && !hang;
  assign m_ready[1] = (mc_cnt[1] == 2'd0) && !hang;

  // Controller model: accepts on m_mem while ready, then busy for two cycles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        mc_cnt[i] <= 2'd0; mv[i] <= 1'b0; ma[i] <= '0; md[i] <= '0; m_rdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mc_cnt[i] != 2'd0) begin
          mc_cnt[i] <= mc_cnt[i] - 2'd1;
        end else if (m_mem[i] && m_ready[i]) begin
          mc_cnt[i] <= 2'd2;
          if (!m_rw[i]) begin
            mv[i] <= 1'b1; ma[i] <= m_addr[i]; md[i] <= m_wdata[i];
          end else begin
            m_rdata[i] <= (mv[i] && ma[i] == m_addr[i]) ? md[i] : dflt(m_addr[i]);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rw0 = 1'b1; rw1 = 1'b1; hang = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req0 = 1'b1; rw0 = 1'b1; req1 = 1'b0; hang = 1'b0;
    @(negedge clk); #2;
    checks++;
    if ({ack0[0], ack1[0], done0[0], done1[0], m_mem[0], busy[0], owner[0], terr[0]} !== 8'b0)
      begin failures++; $display("FAIL reset_ctrl got=%b want=00000000",
        {ack0[0], ack1[0], done0[0], done1[0], m_mem[0], busy[0], owner[0], terr[0]}); end
    checks++;
    if ({rdata0[0], rdata1[0]} !== 32'h0) begin failures++;
      $display("FAIL reset_rdata got=%h want=00000000", {rdata0[0], rdata1[0]}); end
    checks++;
    if ({m_rw[0], m_addr[0], m_wdata[0]} !== {1'b1, 18'h0, 16'h0}) begin failures++;
      $display("FAIL reset_bus got rw=%b addr=%h wdata=%h want rw=1 addr=0 wdata=0",
        m_rw[0], m_addr[0], m_wdata[0]); end
    do_reset();
  endtask

  task automatic test_single_read();
    int ack_cyc = -1, done_cyc = -1, mem_cnt = 0, bad1 = 0;
    logic [15:0] rd_at_done = '0;
    logic [7:0]  bpat = '0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin req0 = 1'b1; rw0 = 1'b1; addr0 = 18'h00012; end
      if (c == 1) req0 = 1'b0;
      #2;
      if (ack0[0] && ack_cyc < 0) ack_cyc = c;
      if (m_mem[0]) mem_cnt++;
      if (done0[0]) begin done_cyc = c; rd_at_done = rdata0[0]; end
      if (ack1[0] || done1[0]) bad1++;
      bpat[c] = busy[0];
    end
    checks++;
    if (ack_cyc !== 0) begin failures++; $display("FAIL read_ack_cycle got=%0d want=0", ack_cyc); end
    checks++;
    if (mem_cnt !== 1) begin failures++; $display("FAIL read_mem_count got=%0d want=1", mem_cnt); end
    checks++;
    if (done_cyc !== 3) begin failures++; $display("FAIL read_done_cycle got=%0d want=3", done_cyc); end
    checks++;
    if (rd_at_done !== 16'hBEEF) begin failures++;
      $display("FAIL read_rdata_done got=%h want=beef", rd_at_done); end
    checks++;
    if (rdata0[0] !== 16'hBEEF) begin failures++;
      $display("FAIL read_rdata_held got=%h want=beef", rdata0[0]); end
    checks++;
    if (bad1 !== 0) begin failures++; $display("FAIL read_port1_quiet got=%0d want=0", bad1); end
    checks++;
    if (bpat !== 8'b0000_1110) begin failures++; $display("FAIL read_busy got=%b want=00001110", bpat); end
  endtask

  task automatic test_contention();
    int gc = 0, bad_cyc = 0, both = 0, own_err = 0, fp_g0 = 0, fp_g1 = 0;
    int d0 = 0, d1 = 0, fp_d0 = 0, fp_ack1_cyc = -1;
    logic [5:0] gseq = '0;
    logic last_port [2];
    last_port[0] = 1'b0; last_port[1] = 1'b0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin req0 = 1'b1; req1 = 1'b1; rw0 = 1'b1; rw1 = 1'b1;
        addr0 = 18'h1; addr1 = 18'h2; end
      if (c == 24) req0 = 1'b0;
      if (fp_ack1_cyc >= 0) req1 = 1'b0;
      #2;
      for (int i = 0; i < 2; i++) begin
        if (ack0[i] && ack1[i]) both++;
        if (done0[i] || done1[i]) begin
          if (done1[i] !== last_port[i]) own_err++;
        end
        if (ack0[i] || ack1[i]) last_port[i] = ack1[i];
      end
      if (c < 24) begin
        if (ack0[0] || ack1[0]) begin
          if (gc < 6) gseq[gc] = ack1[0];
          if (c != 4 * gc) bad_cyc++;
          gc++;
        end
        if (done0[0]) d0++;
        if (done1[0]) d1++;
        if (ack0[1]) fp_g0++;
        if (ack1[1]) fp_g1++;
        if (done0[1]) fp_d0++;
      end else if (ack1[1] && fp_ack1_cyc < 0) begin
        fp_ack1_cyc = c;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (gseq !== 6'b101010 || gc !== 6) begin failures++;
      $display("FAIL rr_grant_seq got=%b n=%0d want=101010 n=6", gseq, gc); end
    checks++;
    if (bad_cyc !== 0) begin failures++; $display("FAIL rr_grant_spacing got=%0d want=0", bad_cyc); end
    checks++;
    if (d0 !== 3 || d1 !== 3) begin failures++;
      $display("FAIL rr_done_counts got=%0d/%0d want=3/3", d0, d1); end
    checks++;
    if (both !== 0 || own_err !== 0) begin failures++;
      $display("FAIL contention_owner got both=%0d own_err=%0d want 0/0", both, own_err); end
    checks++;
    if (fp_g0 !== 6 || fp_g1 !== 0 || fp_d0 !== 6) begin failures++;
      $display("FAIL fp_grants got g0=%0d g1=%0d d0=%0d want 6/0/6", fp_g0, fp_g1, fp_d0); end
    checks++;
    if (fp_ack1_cyc !== 24) begin failures++;
      $display("FAIL fp_port1_after_drop got=%0d want=24", fp_ack1_cyc); end
  endtask

  task automatic test_write_read();
    logic [31:0] dmask = '0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin req1 = 1'b1; rw1 = 1'b0; addr1 = 18'h3FFFF; wdata1 = 16'h5A5A; end
      if (c == 1 || c == 5) req1 = 1'b0;
      if (c == 4) begin req1 = 1'b1; rw1 = 1'b1; end
      #2;
      if (done1[0]) dmask[c] = 1'b1;
      if (c == 0) begin
        checks++;
        if ({ack1[0], m_mem[0], m_rw[0], m_addr[0], m_wdata[0]} !==
            {1'b1, 1'b1, 1'b0, 18'h3FFFF, 16'h5A5A}) begin failures++;
          $display("FAIL wr_issue got ack=%b mem=%b rw=%b addr=%h wdata=%h want 1 1 0 3ffff 5a5a",
            ack1[0], m_mem[0], m_rw[0], m_addr[0], m_wdata[0]); end
      end
      if (c == 3) begin
        checks++;
        if (rdata1[0] !== 16'h0) begin failures++;
          $display("FAIL wr_no_rdata got=%h want=0000", rdata1[0]); end
      end
      if (c == 4) begin
        checks++;
        if ({ack1[0], m_rw[0], m_addr[0]} !== {1'b1, 1'b1, 18'h3FFFF}) begin failures++;
          $display("FAIL rd_issue got ack=%b rw=%b addr=%h want 1 1 3ffff",
            ack1[0], m_rw[0], m_addr[0]); end
      end
      if (c == 7 || c == 9) begin
        checks++;
        if (rdata1[0] !== 16'h5A5A) begin failures++;
          $display("FAIL rd_back c%0d got=%h want=5a5a", c, rdata1[0]); end
      end
    end
    checks++;
    if (dmask !== 32'h88) begin failures++; $display("FAIL wr_rd_done1 got=%h want=00000088", dmask); end
  endtask

  task automatic test_timeout();
    logic [31:0] dmask = '0, amask = '0;
    do_reset();
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      if (c == 0 || c == 16) begin req0 = 1'b1; rw0 = 1'b1; addr0 = 18'h00012; end
      if (c == 1) begin req0 = 1'b0; hang = 1'b1; end
      if (c == 16) hang = 1'b0;
      if (c == 17) req0 = 1'b0;
      #2;
      if (done0[0]) dmask[c] = 1'b1;
      if (ack0[0]) amask[c] = 1'b1;
      if (c == 15) begin
        checks++;
        if ({terr[0], rdata0[0]} !== {1'b0, 16'h0}) begin failures++;
          $display("FAIL to_at_done got err=%b rdata=%h want 0 0000", terr[0], rdata0[0]); end
      end
      if (c == 16 || c == 22) begin
        checks++;
        if (terr[0] !== 1'b1) begin failures++;
          $display("FAIL to_sticky c%0d got=%b want=1", c, terr[0]); end
      end
    end
    checks++;
    if (dmask !== 32'h0008_8000) begin failures++;
      $display("FAIL to_done_cycles got=%h want=00088000", dmask); end
    checks++;
    if (amask !== 32'h0001_0001) begin failures++;
      $display("FAIL to_ack_cycles got=%h want=00010001", amask); end
    checks++;
    if (rdata0[0] !== 16'hBEEF) begin failures++;
      $display("FAIL to_next_read got=%h want=beef", rdata0[0]); end
  endtask

  // Runs straight after test_timeout so timeout_err and rdata0 start non-zero.
  task automatic test_reset_mid_busy();
    logic [31:0] dmask = '0, amask = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin req0 = 1'b1; rw0 = 1'b1; addr0 = 18'h5; end
      if (c == 1) begin
        req0 = 1'b0;
        checks++;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b want=1", busy[0]); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ack0[0], ack1[0], done0[0], done1[0], m_mem[0], busy[0], owner[0], terr[0],
             rdata0[0]} !== 24'h0) begin failures++;
          $display("FAIL rst_async got=%h want=000000", {ack0[0], ack1[0], done0[0], done1[0],
            m_mem[0], busy[0], owner[0], terr[0], rdata0[0]}); end
      end
      if (c == 3) reset_n = 1'b1;
      if (c == 6) begin req0 = 1'b1; req1 = 1'b1; rw1 = 1'b1; addr1 = 18'h6; end
      if (c == 7) begin req0 = 1'b0; req1 = 1'b0; end
      #2;
      if (done0[0] || done1[0]) dmask[c] = 1'b1;
      if (ack0[0]) amask[c] = 1'b1;
    end
    checks++;
    if (dmask !== 32'h200) begin failures++; $display("FAIL rst_no_done got=%h want=00000200", dmask); end
    checks++;
    if (amask !== 32'h41) begin failures++; $display("FAIL rst_tie_port0 got=%h want=00000041", amask); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_read();
    test_timeout();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
